inst_fetch: RTL
===============

// Module: inst_fetch
// PURPOSE
//  Instruction-fetch initiator that drives the instruction ROM port (chip enable, 16-bit
//  byte address) and samples the returned 16-bit instruction in the same cycle.
//  Holds the PC and presents one registered instruction per cycle to decode over a
//  valid/ready handshake. Supports branch redirect and halt.
// PARAMETERS
//  ADDR_W    16       PC / ROM address width (byte address)
//  INST_W    16       instruction width
//  RESET_PC  16'h0000 PC loaded on reset
//  PC_STEP   2        byte increment per instruction (ROM indexes halfwords, addr[0] unused)
// PORTS
//  clk            in   1       single clock, all state on rising edge
//  rst            in   1       synchronous reset, active-high
//  rom_ce         out  1       ROM chip enable (ChipEnable/ChipDisable encoding)
//  rom_addr       out  ADDR_W  ROM byte address, always equal to the current pc
//  rom_inst       in   INST_W  ROM data, combinational from rom_addr in the same cycle
//  branch_valid   in   1       redirect request, one-cycle pulse
//  branch_target  in   ADDR_W  redirect byte address, bit 0 forced to 0
//  halt_req       in   1       stop fetching after the current cycle
//  id_ready       in   1       decode accepts if_inst this cycle
//  if_valid       out  1       if_inst/if_pc hold a valid instruction
//  if_inst        out  INST_W  registered instruction
//  if_pc          out  ADDR_W  byte address of if_inst
//  halted         out  1       high while in HALT
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=IDLE, if_valid=0, if_inst=ZeroWord, if_pc=0, halted=0, rom_ce=0.
//  rst overrides every other input, including mid-operation. All outputs reach reset values
//  at the first edge with rst=1.
//  States (fetch_state_t):
//    IDLE  rom_ce=0. Goes to RUN on the next edge. Gives one dead cycle after reset.
//    RUN   rom_ce=1. load = !if_valid || id_ready.
//    HALT  rom_ce=0, halted=1.
//  RUN, no branch, load=1: if_inst<=rom_inst, if_pc<=pc, if_valid<=1, pc<=pc+PC_STEP.
//  RUN, load=0 (stall): if_* and pc hold, rom_ce stays 1, no instruction lost or duplicated.
//  Handshake: a transfer occurs on an edge with if_valid & id_ready. if_* must not change
//    while if_valid=1 & id_ready=0, except on a branch flush.
//  Branch (any state except IDLE): pc<=branch_target&~1 and if_valid<=0 at the next edge.
//    The instruction currently on rom_inst is discarded. Branch beats stall and halt_req
//    in the same cycle. A branch in HALT returns to RUN.
//  halt_req in RUN with no branch: the current load still completes, then state goes to HALT.
//    pc already points at the next unfetched instruction. A pending if_valid is kept until
//    decode accepts it.
//  Latency: first if_valid=1 is two edges after rst deasserts. Branch-to-target on if_pc
//    takes two edges. Throughput is one instruction per cycle when id_ready=1.
//  Arithmetic: pc+PC_STEP is modulo 2^ADDR_W, so 16'hFFFE wraps to 16'h0000 with no flag.
//  rom_addr = pc at all times, including IDLE and HALT (ROM is gated by rom_ce).
// STRUCTURE
//  Shared package / defines: fetch_state_t {IDLE,RUN,HALT}, RESET_PC, PC_STEP;
//    reuse the existing ChipEnable/ChipDisable, ZeroWord and InstBus macros.
//  One sub-module: if_pc_gen, containing the PC register and the next-PC mux
//    (hold / +PC_STEP / branch / reset).
//  The top holds the FSM and the IF/ID output register.
//  The bench uses a behavioural ROM model with mem[addr[15:1]] = {addr[15:1]} ^ 16'hA5A5.
// TESTING
//  1 Reset release, id_ready=1: rom_ce=0 for one cycle, then if_pc=0000,0002,0004 with
//    the matching if_inst on consecutive cycles; if_valid first rises at edge 2.
//  2 Stall: id_ready=0 for 3 cycles while if_pc=0004: if_inst/if_pc stay constant and
//    pc stays 0006. After release the next if_pc=0006 with no gap or duplicate.
//  3 Branch: branch_valid with target 0x0101 while id_ready=0: next cycle if_valid=0;
//    the cycle after, if_pc=0x0100 and pc=0x0102.
//  4 Wrap: branch to 0xFFFC, free run: if_pc=FFFC,FFFE,0000,0002.
//  5 Halt: halt_req at pc=0010: the fetch of 0010 completes, then halted=1, rom_ce=0 and
//    no new if_valid. A branch to 0x0040 resumes with if_pc=0040.
//  6 Mid-run reset: assert rst while if_valid=1 and stalled: the next edge gives all reset
//    values. The sequence then restarts from RESET_PC per scenario 1.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared widths, reset/step constants, chip-enable encoding and fetch FSM states
package inst_fetch_pkg;
  localparam int ADDR_W = 16;
  localparam int INST_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
  localparam logic [ADDR_W-1:0] PC_STEP = 16'd2;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  typedef logic [INST_W-1:0] inst_bus_t;
  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/if_pc_gen.sv
// if_pc_gen: PC register with hold / +PC_STEP / branch / reset next-PC mux
//   clk, rst          clock and synchronous active-high reset
//   inc_i             advance pc by PC_STEP
//   br_i, br_target_i load halfword-aligned branch target (wins over inc_i)
//   pc_o              current pc
module if_pc_gen import inst_fetch_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              br_i,
  input  logic [ADDR_W-1:0] br_target_i,
  output logic [ADDR_W-1:0] pc_o
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  always_comb pc_d = br_i ? (br_target_i & ~ADDR_W'(1)) : inc_i ? pc_q + PC_STEP : pc_q;
  always_ff @(posedge clk) pc_q <= rst ? RESET_PC : pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch initiator driving the ROM port and a valid/ready IF/ID register
//   clk, rst                      clock and synchronous active-high reset
//   rom_ce, rom_addr, rom_inst    ROM port; rom_addr is always the pc, data returns same cycle
//   branch_valid, branch_target   redirect pulse and byte target
//   halt_req                      stop fetching after the current cycle
//   id_ready                      decode accepts if_inst this cycle
//   if_valid, if_inst, if_pc      registered instruction to decode
//   halted                        high while in HALT
module inst_fetch import inst_fetch_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  inst_bus_t         rom_inst,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt_req,
  input  logic              id_ready,
  output logic              if_valid,
  output inst_bus_t         if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted
);
  fetch_state_t state_q, state_d;
  logic if_valid_q, if_valid_d;
  inst_bus_t if_inst_q, if_inst_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d, pc;
  logic br, ld;
  if_pc_gen u_pc_gen (
    .clk(clk),
    .rst(rst),
    .inc_i(ld),
    .br_i(br),
    .br_target_i(branch_target),
    .pc_o(pc)
  );
  // a branch flushes the IF/ID register and discards the word on rom_inst;
  // outside a branch, the register only drains in HALT
  always_comb begin
    br = branch_valid && state_q != IDLE;
    ld = state_q == RUN && !br && (!if_valid_q || id_ready);
    state_d = (state_q == IDLE || br) ? RUN : (state_q == RUN && halt_req) ? HALT : state_q;
    if_valid_d = br ? 1'b0 : ld ? 1'b1 : id_ready ? 1'b0 : if_valid_q;
    if_inst_d = ld ? rom_inst : if_inst_q;
    if_pc_d = ld ? pc : if_pc_q;
    rom_ce = state_q == RUN ? CHIP_ENABLE : CHIP_DISABLE;
    halted = state_q == HALT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      if_valid_q <= 1'b0;
      if_inst_q <= ZERO_WORD;
      if_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if_valid_q <= if_valid_d;
      if_inst_q <= if_inst_d;
      if_pc_q <= if_pc_d;
    end
  end
  assign rom_addr = pc;
  assign if_valid = if_valid_q;
  assign if_inst = if_inst_q;
  assign if_pc = if_pc_q;
endmodule
